// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data/strobe inputs and segment/anode outputs of the scan driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [7:0]              SEG;
    logic [NUM_DIGITS-1:0]   AN;

    modport master (
        output data, dp, digit_en, load,
        input  SEG, AN
    );

    modport slave (
        input  data, dp, digit_en, load,
        output SEG, AN
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with frame-synchronous shadow update
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d, shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, shadow_dp_q, shadow_dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick, frame_end, lz_blank;
    logic [3:0]              nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h18;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick      = (pcnt_q == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (idx_q == IW'(NUM_DIGITS - 1));
    assign nib       = shadow_q[{idx_q, 2'b00} +: 4];

    // A load on the frame-boundary cycle goes straight through pending into the shadow.
    always_comb begin
        pcnt_d      = tick ? '0 : pcnt_q + 1'b1;
        idx_d       = idx_q;
        if (tick) idx_d = frame_end ? '0 : idx_q + 1'b1;
        pend_d      = bus.load ? bus.data : pend_q;
        pend_dp_d   = bus.load ? bus.dp   : pend_dp_q;
        shadow_d    = frame_end ? pend_d    : shadow_q;
        shadow_dp_d = frame_end ? pend_dp_d : shadow_dp_q;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic hi_zero;
    always_comb begin
        lz_blank = 1'b0;
        hi_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero && (shadow_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i) && hi_zero && !shadow_dp_q[i]) lz_blank = 1'b1;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Slot position 0 produces the anti-ghosting blank; digit_en is sampled live.
    always_comb begin
        seg_d = 8'hFF;
        an_d  = '1;
        if (pcnt_q != '0 && bus.digit_en[idx_q] && !lz_blank) begin
            an_d[idx_q] = 1'b0;
            seg_d       = {~shadow_dp_q[idx_q], hex7(nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            seg_q       <= 8'hFF;
            an_q        <= '1;
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign bus.SEG = seg_q;
    assign bus.AN  = an_q;
endmodule
